// File: rtl/muxn_pipe_pkg.sv
// rtl/muxn_pipe_pkg.sv - shared pipeline defines: occupancy encodings and width helpers
package muxn_pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_FULL  = 2'b10
    } occ_e;

    // Ceiling log2 for elaboration-time width calculation.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Select width never collapses to zero bits.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/muxn_pipe_skid_buf.sv
// rtl/muxn_pipe_skid_buf.sv - 2-entry valid/ready skid buffer with registered ready
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_flush             synchronous clear of both entries (wins over accept)
//   i_valid/o_ready     upstream handshake; o_ready is a flop
//   i_data              upstream beat
//   o_valid/i_ready     downstream handshake
//   o_data              downstream beat, driven straight from the MAIN register
module skid_buf
    import muxn_pipe_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    occ_e         r_state;
    occ_e         w_state_next;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_in_ready;

    logic         w_accept;
    logic         w_xfer;
    logic         w_load_main;
    logic         w_load_skid;
    logic         w_skid_to_main;

    assign o_valid  = (r_state != OCC_EMPTY);
    assign o_ready  = r_in_ready;
    assign o_data   = r_main;
    assign w_accept = i_valid && r_in_ready;
    assign w_xfer   = o_valid && i_ready;

    always_comb begin
        w_state_next   = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (i_flush) begin
            // MAIN keeps its contents so the outputs hold their last value.
            w_state_next = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = OCC_ONE;
                        w_load_main  = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_xfer) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = OCC_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_xfer) begin
                        w_state_next = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // o_ready is low here, so no accept can coincide.
                    if (w_xfer) begin
                        w_state_next   = OCC_ONE;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: begin
                    w_state_next = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= OCC_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            // Ready is computed from the next state so it is a pure flop output.
            r_in_ready <= (w_state_next != OCC_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= i_data;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// rtl/muxn_pipe.sv - registered N:1 channel selector with valid/ready and out-of-range flag
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous drop of all buffered beats
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   data_in             NUM_IN channels, channel i at [i*WIDTH +: WIDTH]
//   sel                 channel select, sampled with the beat
//   out_valid/out_ready downstream handshake
//   out_data/out_err    selected value and out-of-range flag, from flops
module muxn_pipe
    import muxn_pipe_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 8,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err
);

    logic [WIDTH-1:0] w_data;
    logic             w_err;
    logic [WIDTH:0]   w_beat;
    logic [WIDTH:0]   w_out_beat;

    // An out-of-range select matches no channel, so data falls back to zero.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                w_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    generate
        if (NUM_IN == (1 << SEL_W)) begin : g_err_none
            assign w_err = 1'b0;
        end else begin : g_err_cmp
            assign w_err = (sel >= SEL_W'(NUM_IN));
        end
    endgenerate

    assign w_beat = {w_err, w_data};

    skid_buf #(
        .W (WIDTH + 1)
    ) u_skid_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_beat),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_beat)
    );

    assign out_err  = w_out_beat[WIDTH];
    assign out_data = w_out_beat[WIDTH-1:0];

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised N:1 selector, the next generation of the fixed 8-way mux used in the simple pipeline.
- Generalised in channel count and width. Adds a registered output with a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, an out-of-range select flag and a synchronous flush.
- Sits between the pipeline register stages: writeback source select and forwarding select.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_IN, 8, number of input channels, 2..16; not required to be a power of two.
- SEL_W, derived clog2(NUM_IN) (minimum 1), select width; not user-overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all buffered beats
- in_valid  input  1  upstream beat present
- in_ready  output  1  block can accept a beat this cycle
- data_in  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- sel  input  SEL_W  channel select, sampled with the beat
- out_valid  output  1  out_data/out_err hold a beat
- out_ready  input  1  downstream accepts the beat this cycle
- out_data  output  WIDTH  selected channel value
- out_err  output  1  beat was taken with sel >= NUM_IN

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). Reset clears every state element immediately.
- Reset values: out_valid=0, out_data=0, out_err=0, in_ready=1, occupancy=EMPTY.
- Accept and transfer:
  - An input beat is accepted when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Select evaluation:
  - Evaluated combinationally at accept time and stored as {data, err}.
  - sel >= NUM_IN stores data=0, err=1. Otherwise data is the selected channel and err=0.
- Latency: a beat accepted in cycle t appears on out_data with out_valid=1 in cycle t+1. Throughput is 1 beat/cycle while out_ready=1.
- Storage:
  - MAIN register drives the outputs.
  - SKID register holds one overflow beat.
  - out_data/out_err come directly from MAIN flops; no combinational path from data_in to outputs.
- in_ready is registered and equals (occupancy != FULL). There is no combinational path from out_ready to in_ready.
- Occupancy FSM (states EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE, beat loads MAIN.
  - ONE, accept && transfer -> ONE, beat loads MAIN.
  - ONE, accept only -> FULL, beat loads SKID.
  - ONE, transfer only -> EMPTY.
  - ONE, neither -> ONE.
  - FULL (in_ready=0, no accept): transfer -> ONE, SKID moves to MAIN. Otherwise hold.
- Ordering: strictly FIFO; SKID never bypasses MAIN.
- Flush:
  - Next state is EMPTY, out_valid=0, in_ready=1. out_data/out_err hold their last values.
  - Flush has priority over a simultaneous accept; that beat is dropped even though in_ready was 1.
  - A simultaneous transfer still counts as completed downstream.
- Stability: while out_valid=1 and out_ready=0, out_data/out_err must not change.
- Reset mid-operation: buffered beats are lost and no spurious out_valid pulse is produced.
- No arithmetic beyond the sel >= NUM_IN compare, done at SEL_W bits. When NUM_IN is a power of two, out_err is constant 0.

Decomposition:
- Shared header (pipeline common defines):
  - clog2 constant function.
  - Occupancy state encodings: EMPTY=2'b00, ONE=2'b01, FULL=2'b10.
- One natural sub-module: skid_buf, a WIDTH+1 bit 2-entry valid/ready skid buffer.
  - muxn_pipe = combinational select/err stage + skid_buf.
  - skid_buf is reusable for the other pipeline stages.

Test Plan:
1. Reset and basic select: rst_n low mid-run, then release. With NUM_IN=8, WIDTH=32, data_in channel i = 32'h1000_0000+i, sel=5, in_valid=1, out_ready=1:
   - out_valid=0 during reset.
   - First beat gives out_data=32'h1000_0005, out_err=0 one cycle after accept.
   - Then one beat per cycle.
2. Backpressure fill: stream sel=0,1,2,3 with out_ready=0 from cycle 1.
   - After 2 accepts, in_ready=0 and MAIN holds ch0.
   - Raising out_ready gives outputs ch0, ch1, ch2, ch3 in order, no loss and no duplicate.
3. Out-of-range select: NUM_IN=6, sel=3'd7 -> out_data=0, out_err=1. The next beat with sel=2 gives ch2 with out_err=0.
4. Flush with simultaneous accept: in FULL state, assert flush with in_valid=1.
   - Next cycle out_valid=0, in_ready=1.
   - The flushed beats and the concurrent input never appear on the output.
5. Stability under stall: out_valid=1, out_ready=0 for 5 cycles while data_in and sel change randomly -> out_data/out_err constant.
6. Random valid/ready: 10k random cycles on in_valid/out_ready against a scoreboard FIFO model.
   - Order and values match.
   - Occupancy is never above 2.
   - in_ready=0 only in FULL.
